// File: rtl/spi_slave_byte_if.sv
// Pin and FIFO bundle for spi_slave_byte: SPI mode-0 pins, RX push side, TX pull side and status.
// The slave modport is the endpoint's view; the master modport is the surrounding environment's view.
interface spi_slave_byte_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       io_update;
    logic       miso;
    logic [7:0] data_o;
    logic       wrreq;
    logic       have_data;
    logic [7:0] data_i;
    logic       rdreq;
    logic       update;
    logic       busy;

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        input  io_update,
        input  have_data,
        input  data_i,
        output miso,
        output data_o,
        output wrreq,
        output rdreq,
        output update,
        output busy
    );

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        output io_update,
        output have_data,
        output data_i,
        input  miso,
        input  data_o,
        input  wrreq,
        input  rdreq,
        input  update,
        input  busy
    );
endinterface

// File: rtl/spi_slave_byte.sv
// Oversampling SPI mode-0 byte slave: RX bytes pushed via wrreq, TX bytes pulled via rdreq.
// Optional macro SPI_SLAVE_PARTIAL_ERR_EN adds err_cnt/err_clr for counting aborted partial bytes.
module spi_slave_byte #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SPI_SLAVE_PARTIAL_ERR_EN
    input  logic       err_clr,
    output logic [7:0] err_cnt,
`endif
    spi_slave_byte_if.slave bus
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES:0]   sclk_sync;
    logic [SYNC_STAGES:0]   cs_sync;
    logic [SYNC_STAGES:0]   upd_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic upd_rise;
    logic mosi_bit;

    logic frame_start;
    logic frame_end;
    logic rx_step;
    logic tx_step;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic [7:0] load_byte;
    logic       wr_pend;
    logic       rd_pend;
    logic       upd_pend;

    logic       miso_q;
    logic [7:0] data_q;
    logic       wrreq_q;
    logic       rdreq_q;
    logic       update_q;
    logic       busy_q;

    // cs_n chain resets high so a released reset with the pin idle produces no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            upd_sync  <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], bus.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-1:0], bus.cs_n};
            upd_sync  <= {upd_sync[SYNC_STAGES-1:0], bus.io_update};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_sync[SYNC_STAGES];
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_sync[SYNC_STAGES];
    assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_sync[SYNC_STAGES];
    assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_sync[SYNC_STAGES];
    assign upd_rise  = upd_sync[SYNC_STAGES-1] & ~upd_sync[SYNC_STAGES];
    assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE:  if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A deselect seen together with an sclk edge swallows that edge.
    always_comb begin
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_step     = 1'b0;
        tx_step     = 1'b0;
        case (state)
            IDLE: begin
                frame_start = cs_fall;
            end
            ACTIVE: begin
                frame_end = cs_rise;
                rx_step   = sclk_rise & ~cs_rise;
                tx_step   = sclk_fall & ~cs_rise;
            end
            default: begin
                frame_start = 1'b0;
            end
        endcase
    end

    assign load_byte = bus.have_data ? bus.data_i : FILL_BYTE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            tx_shift <= '0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            if (frame_start) begin
                bit_cnt  <= '0;
                tx_shift <= load_byte;
                rd_pend  <= bus.have_data;
            end else if (frame_end) begin
                bit_cnt <= '0;
            end else if (rx_step) begin
                rx_shift <= {rx_shift[5:0], mosi_bit};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_byte <= {rx_shift, mosi_bit};
                    wr_pend <= 1'b1;
                end
            end else if (tx_step) begin
                // A falling edge at bit 0 is a byte boundary, including the trailing one of a burst.
                if (bit_cnt == 3'd0) begin
                    tx_shift <= load_byte;
                    rd_pend  <= bus.have_data;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_pend <= 1'b0;
        end else begin
            upd_pend <= upd_rise;
        end
    end

`ifdef SPI_SLAVE_PARTIAL_ERR_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (err_clr) begin
            err_cnt_q <= 8'h00;
        end else if (frame_end && (bit_cnt != 3'd0) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Partial bytes are dropped silently when the error counter is not built.
`endif

    // Registered outputs, one cycle behind the internal state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_q   <= 1'b0;
            data_q   <= 8'h00;
            wrreq_q  <= 1'b0;
            rdreq_q  <= 1'b0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            miso_q   <= (state == ACTIVE) & tx_shift[7];
            wrreq_q  <= wr_pend;
            rdreq_q  <= rd_pend;
            update_q <= upd_pend;
            busy_q   <= (state == ACTIVE);
            if (wr_pend) begin
                data_q <= rx_byte;
            end
        end
    end

    assign bus.miso   = miso_q;
    assign bus.data_o = data_q;
    assign bus.wrreq  = wrreq_q;
    assign bus.rdreq  = rdreq_q;
    assign bus.update = update_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: acts as the SPI byte master and models the RX/TX FIFOs.
`timescale 1ns/1ps
module tb_spi_slave_byte;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_slave_byte_if bus();

`ifdef SPI_SLAVE_PARTIAL_ERR_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;
`endif

    spi_slave_byte #(
        .SYNC_STAGES(2),
        .FILL_BYTE  (8'h00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef SPI_SLAVE_PARTIAL_ERR_EN
        .err_clr(err_clr),
        .err_cnt(err_cnt),
`endif
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    int wr_cnt      = 0;
    int rd_cnt      = 0;
    int upd_cnt     = 0;
    int miso_hi_cnt = 0;

    logic [7:0] wr_log[$];
    logic [7:0] tx_q[$];

    // rd_cnt doubles as the read pointer of the show-ahead TX FIFO.
    always @(negedge clk) begin
        if (bus.wrreq) begin
            wr_cnt++;
            wr_log.push_back(bus.data_o);
        end
        if (bus.rdreq) rd_cnt++;
        if (bus.update) upd_cnt++;
        if (bus.miso) miso_hi_cnt++;
        bus.have_data = (tx_q.size() > rd_cnt);
        bus.data_i    = (tx_q.size() > rd_cnt) ? tx_q[rd_cnt] : 8'h00;
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            waitClk(HALF);
            rx = {rx[6:0], bus.miso};
            bus.sclk = 1'b1;
            waitClk(HALF);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic csLow();
        bus.cs_n = 1'b0;
        waitClk(HALF);
    endtask

    task automatic csHigh();
        waitClk(HALF);
        bus.cs_n = 1'b1;
        waitClk(HALF + 4);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_miso"},   bus.miso,   32'h0);
        checkOutput({tag, "_data_o"}, bus.data_o, 32'h0);
        checkOutput({tag, "_wrreq"},  bus.wrreq,  32'h0);
        checkOutput({tag, "_rdreq"},  bus.rdreq,  32'h0);
        checkOutput({tag, "_update"}, bus.update, 32'h0);
        checkOutput({tag, "_busy"},   bus.busy,   32'h0);
`ifdef SPI_SLAVE_PARTIAL_ERR_EN
        checkOutput({tag, "_err_cnt"}, err_cnt,   32'h0);
`endif
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] rx_b[3];
        int wr0;
        int rd0;
        int upd0;
        int mh0;

        bus.sclk      = 1'b0;
        bus.cs_n      = 1'b1;
        bus.mosi      = 1'b0;
        bus.io_update = 1'b0;

        waitClk(3);
        checkResetOutputs("por");
        rst = 1'b0;
        waitClk(5);

        $display("[TB] single byte A5, TX FIFO empty at frame start");
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        csLow();
        checkOutput("t1_busy_high", bus.busy, 32'h1);
        checkOutput("t1_no_rdreq_at_start", rd_cnt - rd0, 32'd0);
        tx_q.push_back(8'h5A);
        applyStimulus(8'hA5, 8, rx);
        csHigh();
        checkOutput("t1_wr_count", wr_cnt - wr0, 32'd1);
        checkOutput("t1_data", wr_log[wr0], 32'hA5);
        checkOutput("t1_miso_byte", rx, 32'h00);
        checkOutput("t1_trailing_rdreq", rd_cnt - rd0, 32'd1);
        checkOutput("t1_busy_low", bus.busy, 32'h0);
        checkOutput("t1_data_held", bus.data_o, 32'hA5);

        $display("[TB] three-byte burst");
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h77);
        waitClk(2);
        csLow();
        applyStimulus(8'h12, 8, rx_b[0]);
        applyStimulus(8'h34, 8, rx_b[1]);
        applyStimulus(8'h56, 8, rx_b[2]);
        csHigh();
        checkOutput("t2_wr_count", wr_cnt - wr0, 32'd3);
        checkOutput("t2_data0", wr_log[wr0],     32'h12);
        checkOutput("t2_data1", wr_log[wr0 + 1], 32'h34);
        checkOutput("t2_data2", wr_log[wr0 + 2], 32'h56);
        checkOutput("t2_miso0", rx_b[0], 32'hC3);
        checkOutput("t2_miso1", rx_b[1], 32'h3C);
        checkOutput("t2_miso2", rx_b[2], 32'hFF);
        checkOutput("t2_rd_count", rd_cnt - rd0, 32'd4);

        $display("[TB] partial byte aborted after 5 bits");
        wr0 = wr_cnt;
        csLow();
        applyStimulus(8'hF0, 5, rx);
        csHigh();
        checkOutput("t3_no_wrreq", wr_cnt - wr0, 32'd0);
        checkOutput("t3_data_held", bus.data_o, 32'h56);
`ifdef SPI_SLAVE_PARTIAL_ERR_EN
        checkOutput("t3_err_cnt", err_cnt, 32'h1);
`endif

        $display("[TB] io_update with sclk toggling and cs_n high");
        wr0  = wr_cnt;
        rd0  = rd_cnt;
        upd0 = upd_cnt;
        mh0  = miso_hi_cnt;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) bus.io_update = 1'b1;
            if (i == 4) bus.io_update = 1'b0;
            bus.sclk = 1'b1;
            waitClk(HALF);
            bus.sclk = 1'b0;
            waitClk(HALF);
        end
        waitClk(6);
        checkOutput("t4_update_count", upd_cnt - upd0, 32'd1);
        checkOutput("t4_no_wrreq", wr_cnt - wr0, 32'd0);
        checkOutput("t4_no_rdreq", rd_cnt - rd0, 32'd0);
        checkOutput("t4_miso_low", miso_hi_cnt - mh0, 32'd0);

        $display("[TB] reset in the middle of a byte");
        csLow();
        applyStimulus(8'hC0, 4, rx);
        rst = 1'b1;
        waitClk(2);
        checkResetOutputs("t5_in_reset");
        bus.cs_n = 1'b1;
        waitClk(3);
        rst = 1'b0;
        waitClk(6);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        csLow();
        applyStimulus(8'h81, 8, rx);
        csHigh();
        checkOutput("t5_wr_count", wr_cnt - wr0, 32'd1);
        checkOutput("t5_data", wr_log[wr0], 32'h81);
        checkOutput("t5_no_rdreq", rd_cnt - rd0, 32'd0);
        checkOutput("t5_data_held", bus.data_o, 32'h81);

`ifdef SPI_SLAVE_PARTIAL_ERR_EN
        $display("[TB] error counter saturation and clear");
        for (int i = 0; i < 255; i++) begin
            csLow();
            applyStimulus(8'h80, 1, rx);
            csHigh();
        end
        checkOutput("t6_err_255", err_cnt, 32'hFF);
        csLow();
        applyStimulus(8'h80, 1, rx);
        csHigh();
        checkOutput("t6_err_saturated", err_cnt, 32'hFF);
        err_clr = 1'b1;
        waitClk(1);
        err_clr = 1'b0;
        waitClk(1);
        checkOutput("t6_err_cleared", err_cnt, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_byte.md
# spi_slave_byte

Byte-oriented SPI slave endpoint that terminates the link driven by the team's SPI byte master, in mode 0 (SCLK idle low, MSB first). Runs on a local system clock; oversamples SCLK, CS_N, MOSI and IO_UPDATE through synchronizers. Each received byte is pushed to a downstream FIFO via a write strobe. Response bytes for MISO are pulled from an upstream FIFO via a read strobe.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for all four SPI inputs; legal range 2..3.
- FILL_BYTE, 8'h00, byte shifted out on MISO when no TX data is available at a load point.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from master; asynchronous to clk.
- cs_n  input  1  SPI chip select, active low; asynchronous.
- mosi  input  1  SPI data from master; asynchronous.
- io_update  input  1  master commit strobe; asynchronous.
- miso  output  1  SPI data to master.
- data_o  output  8  last received byte; valid while wrreq is high, held until the next byte.
- wrreq  output  1  one-cycle push strobe for data_o.
- have_data  input  1  upstream TX FIFO is not empty.
- data_i  input  8  upstream TX FIFO head, show-ahead.
- rdreq  output  1  one-cycle pop strobe for data_i.
- update  output  1  one-cycle pulse on a synchronized io_update rising edge.
- busy  output  1  high while synchronized cs_n is low.

## Operation
- All four SPI inputs pass through SYNC_STAGES flops and one extra history flop for sclk, cs_n and io_update.
  - Edges are detected from the last two stages.
  - mosi uses the same depth, so it stays aligned with sclk.
- Slave states: IDLE (cs_n high) and ACTIVE (cs_n low).
  - IDLE -> ACTIVE on a cs_n falling edge.
  - ACTIVE -> IDLE on a cs_n rising edge.
- Entering ACTIVE:
  - bit_cnt (3 bits) is cleared.
  - The TX shift register loads data_i with a rdreq pulse if have_data is 1; otherwise it loads FILL_BYTE with no rdreq.
- sclk rising edge in ACTIVE:
  - rx_shift = {rx_shift[6:0], mosi}.
  - bit_cnt increments and wraps from 7 to 0.
  - On the wrap: data_o <= {rx_shift[6:0], mosi}, and wrreq pulses.
- sclk falling edge in ACTIVE:
  - If bit_cnt == 0, a byte boundary: load the next TX byte using the same have_data/FILL_BYTE rule.
  - Otherwise, shift the TX register left by 1.
- miso = TX register bit 7 while ACTIVE; 0 in IDLE.
- The trailing sclk falling edge after the last byte of a burst performs a load and therefore consumes one TX byte (rdreq). The master side accounts for this prefetch.
- sclk edges in IDLE are ignored. The master keeps toggling sclk during io_update.
- cs_n rising mid-byte (bit_cnt != 0): the partial byte is discarded, with no wrreq and data_o unchanged. bit_cnt is cleared.
- An io_update rising edge produces update regardless of state.

## Timing
- Reset values: miso 0, data_o 8'h00, wrreq 0, rdreq 0, update 0, busy 0. Internal state is IDLE, bit_cnt 0, shift registers 0.
- Reset asserted mid-byte aborts immediately. No strobes are issued on release.
- Latency with SYNC_STAGES = 2: let N be the first clk edge that samples an input pin transition.
  - wrreq, rdreq, update and busy change at edge N+3.
  - miso changes at edge N+3 after the pin sclk falling edge.
- Input constraint: sclk high and low phases are each at least SYNC_STAGES+2 clk periods.
  - With the master at CLK_DIV_EVEN = 8, this requires f_clk of at least f_master_clk.
- Simultaneous events:
  - A cs_n rising edge detected in the same cycle as an sclk edge takes priority; the sclk edge is ignored.
  - A cs_n falling edge in the same cycle as an sclk edge: the load wins, and the sclk edge is ignored.
- wrreq and rdreq never assert in the same cycle. They come from opposite sclk edges, which are at least 3 clk apart.

## Configuration
- SPI_SLAVE_PARTIAL_ERR_EN defined:
  - Adds output port err_cnt [7:0], reset 0.
  - err_cnt increments, saturating at 8'hFF, on every cs_n rising edge with bit_cnt != 0.
  - Adds input err_clr: a synchronous clear, which wins over a simultaneous increment.
- Macro undefined: the ports are absent, and partial bytes are silently dropped with no other change.

## Test plan
- Reset, then master sends 8'hA5 with have_data=0 -> one wrreq with data_o=8'hA5; miso carries 8'h00; one rdreq from the trailing load.
- Burst 8'h12, 8'h34, 8'h56 with TX FIFO holding 8'hC3, 8'h3C, 8'hFF -> three wrreq with data_o 12/34/56 in order; MISO bytes C3/3C/FF; four rdreq total.
- cs_n rises after 5 bits of 8'hF0 -> no wrreq, data_o unchanged; err_cnt=1 with SPI_SLAVE_PARTIAL_ERR_EN.
- io_update pulse after a burst while sclk toggles with cs_n high -> exactly one update pulse; no wrreq, no rdreq, miso stays 0.
- rst asserted at bit 4 of a byte, released, then a new 8'h81 frame -> outputs at reset values during reset; only one wrreq, with 8'h81.
- err_cnt forced to 8'hFF by 255 partial frames plus one more -> stays 8'hFF; err_clr -> 8'h00.
